// File: rtl/stage_sequencer_pkg.sv
// Shared encodings for the stage sequencer: FSM states, instruction types and
// I-type function codes.
package stage_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StFetch  = 3'd1;
    localparam state_t StDecode = 3'd2;
    localparam state_t StExec   = 3'd3;
    localparam state_t StMem    = 3'd4;
    localparam state_t StWb     = 3'd5;
    localparam state_t StHalt   = 3'd6;
    localparam state_t StErr    = 3'd7;

    localparam logic [1:0] TypeR = 2'b00;
    localparam logic [1:0] TypeJ = 2'b01;
    localparam logic [1:0] TypeI = 2'b10;
    localparam logic [1:0] TypeS = 2'b11;

    localparam logic [4:0] FuncAndi = 5'd0;
    localparam logic [4:0] FuncAddi = 5'd1;
    localparam logic [4:0] FuncLw   = 5'd2;
    localparam logic [4:0] FuncSw   = 5'd3;
    localparam logic [4:0] FuncBeq  = 5'd4;

endpackage

// File: rtl/stage_path_decode.sv
// Maps a captured instruction type/function to the post-EXEC stages it needs.
module stage_path_decode
    import stage_sequencer_pkg::*;
(
    input  logic [1:0] instr_type,
    input  logic [4:0] func_code,
    output logic       needs_mem,
    output logic       needs_wb
);

    // Anything not explicitly listed behaves like an R-type: write-back only.
    always_comb begin
        needs_mem = 1'b0;
        needs_wb  = 1'b1;
        case (instr_type)
            TypeJ: needs_wb = 1'b0;
            TypeI: begin
                case (func_code)
                    FuncLw:  needs_mem = 1'b1;
                    FuncSw: begin
                        needs_mem = 1'b1;
                        needs_wb  = 1'b0;
                    end
                    FuncBeq: needs_wb = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer with retired-instruction counter.
// Optional MEM-stage timeout is enabled by defining MEM_TIMEOUT_EN.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           instr_type,
    input  logic [4:0]           func_code,
    input  logic                 stop_bit,
    input  logic                 mem_ready,
    output logic                 en_fetch,
    output logic                 en_decode,
    output logic                 en_execute,
    output logic                 en_memory,
    output logic                 en_write_back,
    output logic                 busy,
    output logic                 halted,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] retired_count
);

    state_t               state_q, state_d;
    logic [1:0]           type_q;
    logic [4:0]           func_q;
    logic                 stop_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 retire;
    logic                 needs_mem, needs_wb;

    stage_path_decode u_path_decode (
        .instr_type (type_q),
        .func_code  (func_q),
        .needs_mem  (needs_mem),
        .needs_wb   (needs_wb)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WaitW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);

    logic [WaitW-1:0] wait_q, wait_d;
    logic             wait_expired;

    // This cycle's stall would bring the count to MEM_WAIT_MAX.
    assign wait_expired = (wait_q == WaitW'(MEM_WAIT_MAX - 1));
`endif

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            StIdle, StHalt: if (start) state_d = StFetch;
            StFetch:        state_d = StDecode;
            StDecode:       state_d = StExec;
            StExec: begin
                if (needs_mem) begin
                    state_d = StMem;
`ifdef MEM_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else if (needs_wb) begin
                    state_d = StWb;
                end else begin
                    retire = 1'b1;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    if (needs_wb) state_d = StWb;
                    else          retire  = 1'b1;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_expired) state_d = StErr;
                else                   wait_d  = wait_q + 1'b1;
`endif
            end
            StWb:    retire = 1'b1;
            StErr:   ;
            default: state_d = StIdle;
        endcase
        if (retire) state_d = stop_q ? StHalt : StFetch;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            type_q  <= '0;
            func_q  <= '0;
            stop_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                type_q <= instr_type;
                func_q <= func_code;
                stop_q <= stop_bit;
            end
            if (retire) count_q <= count_q + 1'b1;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wait_q <= '0;
        else          wait_q <= wait_d;
    end

    assign timeout_err = (state_q == StErr);
`else
    assign timeout_err = 1'b0;
`endif

    assign en_fetch      = (state_q == StFetch);
    assign en_decode     = (state_q == StDecode);
    assign en_execute    = (state_q == StExec);
    assign en_memory     = (state_q == StMem);
    assign en_write_back = (state_q == StWb);
    assign busy          = !((state_q == StIdle) || (state_q == StHalt) || (state_q == StErr));
    assign halted        = (state_q == StHalt);
    assign retired_count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer against a stage-list reference model.
// The timeout scenario follows MEM_TIMEOUT_EN when it is defined.
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    localparam int unsigned CW   = 4;
    localparam int unsigned WMAX = 15;

    localparam logic [4:0] EF = 5'b10000;
    localparam logic [4:0] ED = 5'b01000;
    localparam logic [4:0] EE = 5'b00100;
    localparam logic [4:0] EM = 5'b00010;
    localparam logic [4:0] EW = 5'b00001;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    instr_type = '0;
    logic [4:0]    func_code = '0;
    logic          stop_bit = 1'b0;
    logic          mem_ready = 1'b0;
    logic          en_fetch, en_decode, en_execute, en_memory, en_write_back;
    logic          busy, halted, timeout_err;
    logic [CW-1:0] retired_count;

    int errors = 0;
    int checks = 0;
    int model_count = 0;

    always #5 clock = ~clock;

    stage_sequencer #(
        .MEM_WAIT_MAX (WMAX),
        .CNT_WIDTH    (CW)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .instr_type    (instr_type),
        .func_code     (func_code),
        .stop_bit      (stop_bit),
        .mem_ready     (mem_ready),
        .en_fetch      (en_fetch),
        .en_decode     (en_decode),
        .en_execute    (en_execute),
        .en_memory     (en_memory),
        .en_write_back (en_write_back),
        .busy          (busy),
        .halted        (halted),
        .timeout_err   (timeout_err),
        .retired_count (retired_count)
    );

    function automatic logic [4:0] en_vec();
        return {en_fetch, en_decode, en_execute, en_memory, en_write_back};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            checks++;
            if ($countones(en_vec()) > 1) begin
                errors++;
                $display("FAIL onehot: enables=%b, required at most one set", en_vec());
            end
        end
    end

    // Expects the DUT to be in FETCH now; walks the stages the model predicts.
    task automatic run_instr(input logic [1:0] t, input logic [4:0] f, input logic stp,
                             input int w);
        logic [4:0] seq[$];
        bit is_load, is_store, is_branch;
        int mem_seen = 0;
        is_load   = (t == TypeI) && (f == FuncLw);
        is_store  = (t == TypeI) && (f == FuncSw);
        is_branch = (t == TypeJ) || ((t == TypeI) && (f == FuncBeq));
        seq = '{EF, ED, EE};
        if (is_load || is_store) for (int i = 0; i <= w; i++) seq.push_back(EM);
        if (!is_store && !is_branch) seq.push_back(EW);
        for (int k = 0; k < seq.size(); k++) begin
            checks++;
            if (en_vec() !== seq[k] || busy !== 1'b1 || halted !== 1'b0 ||
                timeout_err !== 1'b0 || retired_count !== CW'(model_count)) begin
                errors++;
                $display("FAIL stage t=%0d f=%0d k=%0d: en=%b busy=%b halted=%b to=%b cnt=%0d, %s%b busy=1 halted=0 to=0 cnt=%0d",
                         t, f, k, en_vec(), busy, halted, timeout_err, retired_count,
                         "required en=", seq[k], CW'(model_count));
            end
            start = 1'($urandom);
            if (seq[k] == ED) begin
                instr_type = t;
                func_code  = f;
                stop_bit   = stp;
            end else begin
                instr_type = 2'($urandom);
                func_code  = 5'($urandom);
                stop_bit   = 1'($urandom);
            end
            if (seq[k] == EM) begin
                mem_ready = (mem_seen == w);
                mem_seen++;
            end else begin
                mem_ready = 1'($urandom);
            end
            step();
        end
        model_count++;
        if (stp) begin
            start = 1'b0;
            checks++;
            if (en_vec() !== 5'b0 || halted !== 1'b1 || busy !== 1'b0 ||
                retired_count !== CW'(model_count)) begin
                errors++;
                $display("FAIL halt_entry: en=%b halted=%b busy=%b cnt=%0d, required 0 1 0 %0d",
                         en_vec(), halted, busy, retired_count, CW'(model_count));
            end
            step();
            checks++;
            if (halted !== 1'b1 || en_vec() !== 5'b0) begin
                errors++;
                $display("FAIL halt_hold: halted=%b en=%b, required halted=1 en=0",
                         halted, en_vec());
            end
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        start = 1'b1;
        step();
        step();
        checks++;
        if (en_vec() !== 5'b0 || busy !== 1'b0 || halted !== 1'b0 || timeout_err !== 1'b0 ||
            retired_count !== '0) begin
            errors++;
            $display("FAIL reset_state: en=%b busy=%b halted=%b to=%b cnt=%0d, required all 0",
                     en_vec(), busy, halted, timeout_err, retired_count);
        end
        start = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ready  = 1'($urandom);
            instr_type = 2'($urandom);
            step();
            checks++;
            if (en_vec() !== 5'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: en=%b busy=%b, required en=0 busy=0", en_vec(), busy);
            end
        end
    endtask

    task automatic test_basic();
        kick();
        run_instr(TypeR, 5'd0, 1'b0, 0);
        run_instr(TypeI, FuncLw, 1'b0, 3);
        run_instr(TypeI, FuncBeq, 1'b1, 0);
    endtask

    task automatic test_halt_restart();
        kick();
        run_instr(TypeJ, 5'd17, 1'b0, 0);
        run_instr(TypeI, FuncSw, 1'b0, 2);
        run_instr(TypeS, 5'd5, 1'b0, 0);
        run_instr(TypeI, 5'd6, 1'b0, 0);
        run_instr(TypeI, FuncAddi, 1'b1, 0);
    endtask

    task automatic test_random();
        bit need_kick = 1'b1;
        logic [1:0] t;
        logic [4:0] f;
        logic stp;
        for (int i = 0; i < 30; i++) begin
            if (need_kick) kick();
            t   = 2'($urandom);
            f   = (t == TypeI) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            stp = (i == 29) ? 1'b1 : ($urandom_range(0, 3) == 0);
            run_instr(t, f, stp, $urandom_range(0, 5));
            need_kick = stp;
        end
    endtask

    task automatic test_wrap();
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        model_count = 0;
        kick();
        for (int i = 0; i < 16; i++) run_instr(TypeR, 5'($urandom), (i == 15), 0);
        checks++;
        if (retired_count !== '0) begin
            errors++;
            $display("FAIL wrap: count=%0d, required 0", retired_count);
        end
    endtask

    task automatic test_mem_wait();
        kick();
        instr_type = TypeI;
        func_code  = FuncSw;
        stop_bit   = 1'b1;
        mem_ready  = 1'b0;
        step();
        step();
        step();
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < WMAX; i++) begin
            checks++;
            if (en_vec() !== EM || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL mem_wait %0d: en=%b to=%b, required en=%b to=0",
                         i, en_vec(), timeout_err, EM);
            end
            step();
        end
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (timeout_err !== 1'b1 || en_vec() !== 5'b0 || busy !== 1'b0 ||
                halted !== 1'b0) begin
                errors++;
                $display("FAIL err_hold %0d: to=%b en=%b busy=%b halted=%b, required 1 0 0 0",
                         i, timeout_err, en_vec(), busy, halted);
            end
            step();
        end
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        model_count = 0;
        checks++;
        if (timeout_err !== 1'b0 || retired_count !== '0) begin
            errors++;
            $display("FAIL err_reset: to=%b cnt=%0d, required 0 0", timeout_err, retired_count);
        end
        reset_n = 1'b1;
`else
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (en_vec() !== EM || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL mem_wait %0d: en=%b to=%b, required en=%b to=0",
                         i, en_vec(), timeout_err, EM);
            end
            step();
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        model_count++;
        checks++;
        if (halted !== 1'b1 || retired_count !== CW'(model_count)) begin
            errors++;
            $display("FAIL mem_release: halted=%b cnt=%0d, required 1 %0d",
                     halted, retired_count, CW'(model_count));
        end
`endif
    endtask

    task automatic test_reset_mid_mem();
        kick();
        instr_type = TypeI;
        func_code  = FuncLw;
        stop_bit   = 1'b0;
        mem_ready  = 1'b0;
        step();
        step();
        step();
        step();
        checks++;
        if (en_vec() !== EM) begin
            errors++;
            $display("FAIL pre_reset_mem: en=%b, required %b", en_vec(), EM);
        end
        reset_n = 1'b0;
        #1;
        model_count = 0;
        checks++;
        if (en_vec() !== 5'b0 || busy !== 1'b0 || halted !== 1'b0 || timeout_err !== 1'b0 ||
            retired_count !== '0) begin
            errors++;
            $display("FAIL async_reset: en=%b busy=%b halted=%b to=%b cnt=%0d, required all 0",
                     en_vec(), busy, halted, timeout_err, retired_count);
        end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (en_vec() !== 5'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: en=%b busy=%b, required 0 0", en_vec(), busy);
            end
        end
        kick();
        run_instr(TypeR, 5'd9, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt_restart();
        test_random();
        test_wrap();
        test_mem_wait();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: still running at 500000, required finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
